idu_decode_stage: RTL
=====================

// Module: idu_decode_stage
// PURPOSE
//  Parametrised, registered RV32I/E decode stage between IFU and EXU. Accepts one
//  instruction per valid/ready beat, decodes format/op-class/immediate and reads the
//  GPR file with write-back bypass. Holds one result in an output register.
//  Replaces the combinational decoder: adds flow control, a perf counter and RV32E mode.
// PARAMETERS
//  XLEN    32  datapath width (pc, imm, register data)
//  NR_REG  32  architectural GPR count; 16 selects RV32E (index>=NR_REG illegal)
//  CNT_W   32  width of decoded-instruction counter
// PORTS
//  clk           in   1     clock, all state on rising edge
//  rst           in   1     asynchronous active-low reset
//  in_valid      in   1     IFU offers in_inst/in_pc
//  in_ready      out  1     stage accepts this cycle
//  in_inst       in   32    instruction word
//  in_pc         in   XLEN  pc of in_inst
//  wb_en         in   1     GPR write enable from WBU
//  wb_addr       in   5     GPR write index
//  wb_data       in   XLEN  GPR write data
//  out_valid     out  1     decoded bundle valid
//  out_ready     in   1     EXU consumes bundle
//  out_pc        out  XLEN  pc of bundle
//  out_op        out  4     op class (see BEHAVIOUR)
//  out_funct3    out  3     inst[14:12]
//  out_alt       out  1     inst[30] for OP / SRAI, else 0
//  out_imm       out  XLEN  sign/zero-extended immediate
//  out_rs1_data  out  XLEN  GPR[rs1], bypassed
//  out_rs2_data  out  XLEN  GPR[rs2], bypassed
//  out_rd        out  5     destination index
//  out_rd_wen    out  1     bundle writes rd (0 if rd==0 or illegal)
//  out_illegal   out  1     undecodable instruction
//  dec_count     out  CNT_W accepted-instruction count
// BEHAVIOUR
//  Reset (rst=0, async): out_valid=0, all out_* and dec_count = 0; GPRs = 0.
//  in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
//  On accept: output register loads decode of in_inst next edge; latency 1 cycle.
//  No accept and out_ready=1: out_valid clears. Otherwise bundle held stable.
//  out_op: 0 ILLEGAL,1 LUI,2 AUIPC,3 JAL,4 JALR,5 BRANCH,6 LOAD,7 STORE,8 OPIMM,
//   9 OP,10 EBREAK (exact 32'h00100073). Unknown opcode/funct3 -> 0, out_illegal=1.
//  Illegal also: OP funct7 not 0x00/0x20 (0x20 only for ADD/SUB,SRL/SRA);
//   SLLI/SRLI funct7!=0, SRAI funct7!=0x20; LOAD funct3 3,6,7; STORE funct3>2;
//   BRANCH funct3 2,3; JALR funct3!=0; any used rs1/rs2/rd index >= NR_REG.
//  Immediate: I sext(inst[31:20]); S sext({inst[31:25],inst[11:7]});
//   B sext({inst[31],inst[7],inst[30:25],inst[11:8],0}); U {inst[31:12],12'b0};
//   J sext({inst[31],inst[19:12],inst[20],inst[30:21],0}); OP/EBREAK/illegal 0.
//  GPR: x0 reads 0, writes to x0 or index>=NR_REG ignored. Write on wb_en at edge.
//  Bypass: on accept, if wb_en && wb_addr==rs && rs!=0, latch wb_data, not array.
//  Held-bundle refresh: while out_valid && !out_ready (or no new accept), a wb to
//   the held bundle's rs1/rs2 (nonzero) updates out_rs*_data same edge.
//  Unused rs fields (LUI/AUIPC/JAL: both; I-type/LOAD/JALR: rs2) read as 0.
//  dec_count +1 per accept, wraps at 2^CNT_W-1 -> 0; illegal instructions counted.
//  Accept and consume same cycle: new bundle replaces old, out_valid stays 1.
//  Reset mid-operation: held bundle discarded, no count, in_ready=1 after release.
// TESTING
//  addi x1,x0,-1 (32'hfff00093) accepted -> next cycle op=8, imm=32'hffffffff, rd=1, rd_wen=1.
//  out_ready=0, 3 in_valid beats -> 1st accepted, in_ready=0 after, bundle stable, dec_count=1.
//  wb x5=32'hdead same cycle as accept of add x3,x5,x5 -> rs1_data=rs2_data=32'hdead.
//  NR_REG=16: add x17,x1,x2 -> op=0, illegal=1, rd_wen=0; NR_REG=32 same inst -> op=9.
//  Held beq x2,x3 bundle, wb x3=7 while stalled -> out_rs2_data becomes 7 next edge.
//  CNT_W=4, 17 accepts -> dec_count=1; rst low mid-stall -> out_valid=0 immediately.

Source files
------------

// File: rtl/idu_decode_stage.sv
// Registered RV32I/E decode stage: valid/ready input and output handshake,
// GPR file with write-back bypass, held-bundle operand refresh and an accept counter.
module idu_decode_stage #(
  parameter int XLEN   = 32,
  parameter int NR_REG = 32,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [3:0]       out_op,
  output logic [2:0]       out_funct3,
  output logic             out_alt,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_rs1_data,
  output logic [XLEN-1:0]  out_rs2_data,
  output logic [4:0]       out_rd,
  output logic             out_rd_wen,
  output logic             out_illegal,
  output logic [CNT_W-1:0] dec_count
);

  typedef enum logic [3:0] {
    OP_ILLEGAL = 4'd0,
    OP_LUI     = 4'd1,
    OP_AUIPC   = 4'd2,
    OP_JAL     = 4'd3,
    OP_JALR    = 4'd4,
    OP_BRANCH  = 4'd5,
    OP_LOAD    = 4'd6,
    OP_STORE   = 4'd7,
    OP_OPIMM   = 4'd8,
    OP_OP      = 4'd9,
    OP_EBREAK  = 4'd10
  } op_e;

  localparam logic [5:0] REG_LIM = 6'(NR_REG);

  logic [XLEN-1:0] gpr [32];

  logic [6:0] opc;
  logic [4:0] f_rd, f_rs1, f_rs2;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opc   = in_inst[6:0];
  assign f_rd  = in_inst[11:7];
  assign f3    = in_inst[14:12];
  assign f_rs1 = in_inst[19:15];
  assign f_rs2 = in_inst[24:20];
  assign f7    = in_inst[31:25];

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = XLEN'($signed(in_inst[31:20]));
  assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));

  op_e             d_op;
  logic [XLEN-1:0] d_imm;
  logic            d_alt, d_ok, use_rs1, use_rs2, use_rd;
  logic [4:0]      d_rs1, d_rs2, d_rd;
  logic [XLEN-1:0] d_rs1_data, d_rs2_data;

  always_comb begin
    d_op    = OP_ILLEGAL;
    d_imm   = '0;
    d_alt   = 1'b0;
    d_ok    = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    unique case (opc)
      7'b0110111: begin d_op = OP_LUI;   d_imm = imm_u; use_rd = 1'b1; d_ok = 1'b1; end
      7'b0010111: begin d_op = OP_AUIPC; d_imm = imm_u; use_rd = 1'b1; d_ok = 1'b1; end
      7'b1101111: begin d_op = OP_JAL;   d_imm = imm_j; use_rd = 1'b1; d_ok = 1'b1; end
      7'b1100111: begin
        d_op = OP_JALR; d_imm = imm_i; use_rs1 = 1'b1; use_rd = 1'b1;
        d_ok = (f3 == 3'd0);
      end
      7'b1100011: begin
        d_op = OP_BRANCH; d_imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1;
        d_ok = (f3 != 3'd2) && (f3 != 3'd3);
      end
      7'b0000011: begin
        d_op = OP_LOAD; d_imm = imm_i; use_rs1 = 1'b1; use_rd = 1'b1;
        d_ok = (f3 != 3'd3) && (f3 < 3'd6);
      end
      7'b0100011: begin
        d_op = OP_STORE; d_imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
        d_ok = (f3 <= 3'd2);
      end
      7'b0010011: begin
        d_op = OP_OPIMM; d_imm = imm_i; use_rs1 = 1'b1; use_rd = 1'b1;
        case (f3)
          3'd1:    d_ok = (f7 == 7'h00);
          3'd5:    begin d_ok = (f7 == 7'h00) || (f7 == 7'h20); d_alt = in_inst[30]; end
          default: d_ok = 1'b1;
        endcase
      end
      7'b0110011: begin
        d_op = OP_OP; use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; d_alt = in_inst[30];
        d_ok = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
      end
      7'b1110011: begin
        if (in_inst == 32'h0010_0073) begin
          d_op = OP_EBREAK; d_ok = 1'b1;
        end
      end
      default: ;
    endcase
    if (use_rs1 && ({1'b0, f_rs1} >= REG_LIM)) d_ok = 1'b0;
    if (use_rs2 && ({1'b0, f_rs2} >= REG_LIM)) d_ok = 1'b0;
    if (use_rd  && ({1'b0, f_rd}  >= REG_LIM)) d_ok = 1'b0;
    // Illegal bundles carry no operands, immediate or destination.
    if (!d_ok) begin
      d_op    = OP_ILLEGAL;
      d_imm   = '0;
      d_alt   = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
    end
  end

  assign d_rs1 = use_rs1 ? f_rs1 : 5'd0;
  assign d_rs2 = use_rs2 ? f_rs2 : 5'd0;
  assign d_rd  = use_rd  ? f_rd  : 5'd0;

  assign d_rs1_data = (d_rs1 == 5'd0) ? '0 : ((wb_en && wb_addr == d_rs1) ? wb_data : gpr[d_rs1]);
  assign d_rs2_data = (d_rs2 == 5'd0) ? '0 : ((wb_en && wb_addr == d_rs2) ? wb_data : gpr[d_rs2]);

  logic wb_ok, accept;
  assign wb_ok    = wb_en && (wb_addr != 5'd0) && ({1'b0, wb_addr} < REG_LIM);
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 32; i++) gpr[i] <= '0;
    end else if (wb_ok) begin
      gpr[wb_addr] <= wb_data;
    end
  end

  // Operand indices of the held bundle, kept so stalled operands track write-back.
  logic [4:0] h_rs1, h_rs2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_op       <= '0;
      out_funct3   <= '0;
      out_alt      <= 1'b0;
      out_imm      <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_rd       <= '0;
      out_rd_wen   <= 1'b0;
      out_illegal  <= 1'b0;
      h_rs1        <= '0;
      h_rs2        <= '0;
      dec_count    <= '0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_op       <= d_op;
      out_funct3   <= f3;
      out_alt      <= d_alt;
      out_imm      <= d_imm;
      out_rs1_data <= d_rs1_data;
      out_rs2_data <= d_rs2_data;
      out_rd       <= d_rd;
      out_rd_wen   <= use_rd && (d_rd != 5'd0);
      out_illegal  <= !d_ok;
      h_rs1        <= d_rs1;
      h_rs2        <= d_rs2;
      dec_count    <= dec_count + CNT_W'(1);
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (wb_en && (h_rs1 != 5'd0) && (wb_addr == h_rs1)) out_rs1_data <= wb_data;
      if (wb_en && (h_rs2 != 5'd0) && (wb_addr == h_rs2)) out_rs2_data <= wb_data;
    end
  end

endmodule
